// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int unsigned PC_W        = 32;
    localparam int unsigned INSTR_W     = 32;
    localparam int unsigned QUEUE_DEPTH = 2;
    localparam logic [5:0]  TRAP_OPCODE = 6'b011010;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_e;

    // One queued fetch result: where it came from and what was read.
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Next sequential word address, wrapping at the end of instruction memory.
    // Assumes pc is already inside the memory range.
    function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc,
                                                input int unsigned    depth_words);
        logic [PC_W-1:0] lim;
        logic [PC_W-1:0] nxt;
        lim = PC_W'(depth_words * 4);
        nxt = pc + PC_W'(4);
        if (nxt >= lim) begin
            nxt = nxt - lim;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry {pc, instr} FIFO between fetch and decode. The head entry is a
// register so decode sees stable outputs straight from flops.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  fetch_entry_t push_entry_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [1:0]   count_o,
    output logic         valid_o,
    output fetch_entry_t head_o
);

    logic [1:0]   count_q, count_d;
    fetch_entry_t head_q,  head_d;
    fetch_entry_t tail_q,  tail_d;

    // Next-state for the two slots; flush drops everything still held.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_d = push_entry_i;
                    end else begin
                        tail_d = push_entry_i;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; new word goes behind whatever remains.
                    if (count_q == 2'd2) begin
                        head_d = tail_q;
                        tail_d = push_entry_i;
                    end else begin
                        head_d = push_entry_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Slot and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign count_o = count_q;
    assign valid_o = (count_q != 2'd0);
    assign head_o  = head_q;

    // The fetch credit rule upstream must keep these from ever firing.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && !pop_i && !flush_i && count_q == 2'd2));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop_i && count_q == 2'd0));

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues one word per cycle to a
// one-cycle-latency instruction memory, buffers results toward decode, and
// handles redirects (flush) and trap halts.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 32,
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter logic [5:0]  TRAP_OP     = TRAP_OPCODE
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        resume,
    output logic        halted
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic            inflight_q, inflight_d;
    logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;

    logic [1:0]      q_count;
    logic            q_valid;
    fetch_entry_t    q_head;
    fetch_entry_t    land_entry;

    logic            pop;
    logic            land;
    logic            trap_land;
    logic [2:0]      occupancy;
    logic            issue;

    assign pop = if_valid & if_ready;

    // A returning word is kept only in FETCH: the word issued on the trap edge
    // lands while already in HALT and is dropped. Redirect discards it too.
    assign land      = inflight_q & (state_q == FETCH) & ~redirect_valid;
    assign trap_land = land & (imem_instr[31:26] == TRAP_OP);

    // Slots committed after this edge: held words plus the landing one, minus
    // the head leaving. Issuing is safe only while that leaves room.
    assign occupancy = 3'(q_count) + 3'(inflight_q) - 3'(pop);
    assign issue     = (state_q == FETCH) & ~redirect_valid & (occupancy < 3'(QUEUE_DEPTH));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: redirect beats trap and resume.
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = FETCH;
        end else if (state_q == FETCH && trap_land) begin
            state_d = HALT;
        end else if (state_q == HALT && halted && resume) begin
            state_d = FETCH;
        end
    end

    // FSM outputs: halt is only reported once everything has drained.
    always_comb begin
        halted = (state_q == HALT) && (q_count == 2'd0) && !inflight_q;
    end

    // PC and in-flight tracking next state.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        if (issue) begin
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = pc_next(fetch_pc_q, DEPTH_WORDS);
        end
        // Restart point after a trap is the word following the trap itself,
        // not whatever was issued alongside the trap landing.
        if (trap_land) begin
            fetch_pc_d = pc_next(inflight_pc_q, DEPTH_WORDS);
        end
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            inflight_d = 1'b0;
        end
    end

    // PC and in-flight registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    assign land_entry = '{pc: inflight_pc_q, instr: imem_instr};

    // Redirect flushes the queue; a head popped in the same cycle has already
    // been taken by decode, so dropping it from storage is correct.
    fetch_queue u_queue (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (land),
        .push_entry_i (land_entry),
        .pop_i        (pop),
        .flush_i      (redirect_valid),
        .count_o      (q_count),
        .valid_o      (q_valid),
        .head_o       (q_head)
    );

    assign imem_pc  = fetch_pc_q;
    assign if_valid = q_valid;
    assign if_instr = q_head.instr;
    assign if_pc    = q_head.pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: expected deliveries are queued when the
// stimulus phase is set up, and a monitor checks every accepted word in order.
module tb_fetch_sequencer;
    import fetch_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        resume;
    logic        halted;

    int n_vec;
    int n_bad;
    int n_seen;

    logic [31:0]  mem [32];
    fetch_entry_t exp_q [$];

    fetch_sequencer #(
        .DEPTH_WORDS (32),
        .RESET_PC    (32'h0),
        .TRAP_OP     (6'b011010)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .resume         (resume),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read instruction memory, one-cycle latency.
    always @(posedge clk) imem_instr <= mem[imem_pc[6:2]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Queue n sequential expected deliveries starting at byte address start.
    task automatic push_seq(input logic [31:0] start, input int n);
        logic [31:0] pc;
        pc = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{pc: pc, instr: mem[pc[6:2]]});
            pc = (pc + 32'd4) % 32'd128;
        end
    endtask

    // Monitor: every accepted head must be the next expected word.
    always @(negedge clk) begin
        if (rst_n && if_valid && if_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL extra_word: got pc %h instr %h, expected no delivery", if_pc, if_instr);
            end else begin
                fetch_entry_t e;
                e = exp_q.pop_front();
                if (if_pc !== e.pc || if_instr !== e.instr) begin
                    n_bad++;
                    $display("FAIL stream[%0d]: got pc %h instr %h, expected pc %h instr %h",
                             n_seen, if_pc, if_instr, e.pc, e.instr);
                end
            end
            n_seen++;
        end
    end

    initial begin
        n_vec  = 0;
        n_bad  = 0;
        n_seen = 0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0C00_0000 | (i << 8) | i;
        mem[29] = 32'h6800_001D;  // trap opcode at byte address 0x74

        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        resume         = 1'b0;
        rst_n          = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_imem_pc",  imem_pc,  32'h0);
        check("reset_if_valid", {31'd0, if_valid}, 32'd0);
        check("reset_if_pc",    if_pc,    32'h0);
        check("reset_if_instr", if_instr, 32'h0);
        check("reset_halted",   {31'd0, halted}, 32'd0);

        // Linear stream 0..56; a stall at 9..13 must not drop or repeat words.
        push_seq(32'h0, 15);
        rst_n = 1'b1;

        for (int c = 0; c <= 62; c++) begin
            @(posedge clk);
            #1;
            if_ready       = !((c >= 9 && c <= 13) || (c >= 20 && c <= 23));
            redirect_valid = (c == 24);
            redirect_pc    = (c == 24) ? 32'h26 : 32'h0;
            resume         = (c == 52);
            case (c)
                1:  check("first_if_pc", if_pc, 32'h0);
                12: begin
                    check("stall_if_pc",   if_pc,   32'd32);
                    check("stall_imem_pc", imem_pc, 32'd40);
                    check("stall_valid",   {31'd0, if_valid}, 32'd1);
                end
                23: begin
                    check("full_if_pc",   if_pc,   32'd56);
                    check("full_imem_pc", imem_pc, 32'd64);
                end
                24: push_seq(32'h24, 21);
                25: begin
                    check("redirect_valid_drop", {31'd0, if_valid}, 32'd0);
                    check("redirect_imem_pc",    imem_pc, 32'h24);
                end
                47: begin
                    check("trap_if_pc",    if_pc, 32'h74);
                    check("trap_not_halt", {31'd0, halted}, 32'd0);
                end
                48, 51: begin
                    check("halted_flag",   {31'd0, halted}, 32'd1);
                    check("halt_valid",    {31'd0, if_valid}, 32'd0);
                    check("halt_imem_pc",  imem_pc, 32'h78);
                end
                52: push_seq(32'h78, 7);
                53: check("resume_clears_halt", {31'd0, halted}, 32'd0);
                57: check("wrap_if_pc", if_pc, 32'h0);
                default: begin
                end
            endcase
        end

        // Asynchronous reset in the middle of back-to-back fetch.
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_valid",   {31'd0, if_valid}, 32'd0);
        check("async_rst_imem_pc", imem_pc,  32'h0);
        check("async_rst_if_pc",   if_pc,    32'h0);
        check("async_rst_instr",   if_instr, 32'h0);
        check("async_rst_halted",  {31'd0, halted}, 32'd0);
        check("pending_at_reset",  32'(exp_q.size()), 32'd0);
        exp_q.delete();

        repeat (2) @(negedge clk);
        push_seq(32'h0, 10);
        if_ready       = 1'b1;
        redirect_valid = 1'b0;
        resume         = 1'b0;
        rst_n          = 1'b1;
        repeat (12) @(posedge clk);
        #1 if_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that sequences the synchronous-read instruction memory (32 words, one-cycle read latency) for the pipelined MIPS core. Owns the program counter and issues one word address per cycle. Buffers returned words in a 2-entry queue toward decode with a valid/ready handshake. Handles branch/jump redirects by flushing, and stops fetching on the trap opcode until resumed.

## Interface
- DEPTH_WORDS, 32, instruction memory depth; PC wraps at DEPTH_WORDS*4
- RESET_PC, 32'h0, PC loaded at reset
- TRAP_OPCODE, 6'b011010, opcode field [31:26] that halts fetch
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- imem_pc  out  32  byte address presented to instruction memory, captured at the next clk edge
- imem_instr  in  32  word for the address presented on the previous edge; valid for the whole following cycle
- if_valid  out  1  queue head holds an instruction
- if_ready  in  1  decode accepts head this cycle
- if_instr  out  32  head instruction
- if_pc  out  32  byte address of head instruction
- redirect_valid  in  1  branch/jump taken; single-cycle pulse
- redirect_pc  in  32  target; bits [1:0] ignored (forced 0)
- resume  in  1  leave HALT
- halted  out  1  in HALT with queue empty

## Operation
- States: FETCH, HALT. Reset: FETCH, fetch_pc=RESET_PC, inflight=0, queue empty. Outputs: imem_pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, halted=0.
- imem_pc = fetch_pc combinationally. Issue occurs on an edge when state=FETCH, redirect_valid=0, and (count + inflight − pop) < 2, where pop = if_valid & if_ready. On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=(fetch_pc+4) mod (DEPTH_WORDS*4).
- Landing: when inflight=1, imem_instr is written into the queue with inflight_pc. The credit rule above guarantees a free slot.
- Trap: landing word with [31:26]=TRAP_OPCODE is queued normally. The edge moves to HALT, and fetch_pc<=inflight_pc+4. The word issued in that same cycle (if any) is discarded on landing. No issue in HALT.
- halted=1 iff state=HALT and queue empty and inflight=0. resume while halted → FETCH. resume at any other time is ignored.
- Redirect (highest priority, any state): the edge flushes the queue except a head popped that same cycle, which counts as delivered. It also discards in-flight data, sets fetch_pc<={redirect_pc[31:2],2'b00}, and sets state=FETCH. Fetch from the target issues on the following edge.
- Simultaneous redirect+resume: redirect wins. Simultaneous trap landing+redirect: redirect wins, and the trap is flushed.
- Queue: 2-entry FIFO, head registered. Pop and push in the same cycle are allowed at any count, including full (credit rule prevents overflow).

## Timing
- Reset release edge E0: issue RESET_PC. E1: word lands in queue, if_valid=1 after E1. Fetch latency is 2 edges.
- Sustained throughput is 1 instr/cycle with if_ready=1.
- if_ready=0: at most 2 words buffered, and issue stops the cycle the credit goes to 0. No word is lost or duplicated.
- Redirect at edge Er: if_valid=0 after Er. Target issued at Er+1, visible after Er+2.
- Trap landing at edge Et: halted rises the cycle after the trap is popped. Resume at edge Eh: issue of trap_pc+4 at Eh+1.
- rst_n assertion mid-operation: all state returns to reset values immediately.

## Structure
- Package fetch_pkg: state enum {FETCH, HALT}, TRAP_OPCODE, QUEUE_DEPTH=2, PC width.
- Sub-module fetch_queue: 2-entry {pc, instr} FIFO with push/pop/flush, count, and async-reset registered head.
- Top holds the FSM, PC, in-flight tracking and credit logic.

## Test plan
- Reset, if_ready=1 → if_pc sequence 0,4,8,… one per cycle starting 2 edges after reset release, matching a memory model.
- if_ready low 5 cycles mid-stream → count saturates at 2, issue stalls, and the stream resumes without gaps or duplicates.
- redirect_pc=32'h26 pulse while queue full → next delivered if_pc=32'h24. The head popped in the redirect cycle is delivered, and no older words follow it.
- Trap word at address 0x74 → delivered with if_pc=0x74, then the 0x78 in-flight word is discarded, halted=1, and no issue. resume → next if_pc=0x78.
- PC at 0x7C (DEPTH_WORDS=32) → next if_pc=0x00.
- rst_n pulsed low during back-to-back fetch → outputs at reset values asynchronously, and restart from RESET_PC.
